l1d_miss_buffer: RTL and testbench

//  Miss/write-through buffer directly downstream of the L1 data cache. Accepts the
//  L1's forwarded requests (read miss, write-through, cache-line flush), queues them,

---
 rtl/l1d_miss_buffer_pkg.sv | 45 ++++
 rtl/l1d_miss_buffer_if.sv | 47 ++++
 rtl/l1d_miss_buffer_miss_fifo.sv | 65 ++++++
 rtl/l1d_miss_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_l1d_miss_buffer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1d_miss_buffer_pkg.sv
// Shared types and constants for the L1D miss/write-through buffer.
// Holds the op encodings, the FSM state type, the queue entry layout and the
// line-alignment helper used when read and flush addresses go to the L2.
package l1d_miss_buffer_pkg;

    localparam int MB_DEPTH   = 4;
    localparam int MB_ADDR_W  = 64;
    localparam int MB_DATA_W  = 64;
    localparam int MB_LINE_W  = 128;
    localparam int LINE_OFF_W = 6;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_CLF = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_RETURN    = 2'd3
    } state_e;

    typedef struct packed {
        op_e                  op;
        logic [MB_ADDR_W-1:0] addr;
        logic [MB_DATA_W-1:0] wdata;
        logic [2:0]           size;
    } req_entry_t;

    // Clear the block-offset bits so the L2 sees a line-aligned address.
    function automatic logic [MB_ADDR_W-1:0] lineAlign(input logic [MB_ADDR_W-1:0] addr);
        return {addr[MB_ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction

    // A flush wins over the write-enable; otherwise the write-enable picks write vs read.
    function automatic op_e decodeOp(input logic we, input logic clf);
        if (clf) begin
            return OP_CLF;
        end
        return we ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/l1d_miss_buffer_if.sv
// Bus bundle between the L1 data cache, the miss buffer and the L2.
// The slave modport is the buffer's view; the master modport is the view of
// whatever drives it (L1 request side plus L2 handshake/response side).
interface l1d_miss_buffer_if;
    import l1d_miss_buffer_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic                 req_clf;
    logic [MB_ADDR_W-1:0] req_addr;
    logic [MB_DATA_W-1:0] req_wdata;
    logic [2:0]           req_size;

    logic                 fill_valid;
    logic [MB_ADDR_W-1:0] fill_addr;
    logic [MB_LINE_W-1:0] fill_data;

    logic                 l2_req_valid;
    logic                 l2_req_ready;
    logic                 l2_we;
    logic                 l2_clf;
    logic [MB_ADDR_W-1:0] l2_addr;
    logic [MB_DATA_W-1:0] l2_wdata;
    logic [2:0]           l2_size;
    logic                 l2_resp_valid;
    logic [MB_LINE_W-1:0] l2_resp_data;

    logic                 err_unexp_resp;

    modport slave (
        input  req_valid, req_we, req_clf, req_addr, req_wdata, req_size,
        input  l2_req_ready, l2_resp_valid, l2_resp_data,
        output req_ready, fill_valid, fill_addr, fill_data,
        output l2_req_valid, l2_we, l2_clf, l2_addr, l2_wdata, l2_size,
        output err_unexp_resp
    );

    modport master (
        output req_valid, req_we, req_clf, req_addr, req_wdata, req_size,
        output l2_req_ready, l2_resp_valid, l2_resp_data,
        input  req_ready, fill_valid, fill_addr, fill_data,
        input  l2_req_valid, l2_we, l2_clf, l2_addr, l2_wdata, l2_size,
        input  err_unexp_resp
    );

endinterface

// File: rtl/l1d_miss_buffer_miss_fifo.sv
// Request queue for the miss buffer: DEPTH entries of {op, addr, wdata, size}.
// Pointers wrap naturally because DEPTH is a power of two; the occupancy count
// is one bit wider than the pointers so that "full" is representable.
module miss_fifo
    import l1d_miss_buffer_pkg::*;
#(
    parameter int DEPTH = MB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  req_entry_t             i_data,
    output req_entry_t             o_head,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    req_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic w_doPush;
    logic w_doPop;

    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && (r_count != FULL_CNT);
    assign w_doPop  = i_pop && !o_empty;
    assign o_head   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    // Entry storage; only written on an accepted push, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/l1d_miss_buffer.sv
// L1D miss/write-through buffer: queues L1 requests, issues them one at a time
// to the L2, and hands read fill lines back to the L1 with a one-cycle pulse.
// Optional feature macro MISSBUF_STATS_EN adds saturating read/write/stall counters.
module l1d_miss_buffer
    import l1d_miss_buffer_pkg::*;
#(
    parameter int DEPTH = MB_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    l1d_miss_buffer_if.slave    bus
`ifdef MISSBUF_STATS_EN
    ,
    output logic [31:0]         o_stat_reads,
    output logic [31:0]         o_stat_writes,
    output logic [31:0]         o_stat_stall
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    state_e r_state;
    state_e w_nextState;

    req_entry_t           w_newEntry;
    req_entry_t           w_head;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    logic                 w_reqReady;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_load;
    logic                 w_respDone;
    logic                 w_readDone;

    op_e                  r_curOp;
    logic                 r_l2We;
    logic                 r_l2Clf;
    logic [MB_ADDR_W-1:0] r_l2Addr;
    logic [MB_DATA_W-1:0] r_l2Wdata;
    logic [2:0]           r_l2Size;
    logic                 r_fillValid;
    logic [MB_ADDR_W-1:0] r_fillAddr;
    logic [MB_LINE_W-1:0] r_fillData;
    logic                 r_err;

    assign w_reqReady = (w_count < FULL_CNT);
    assign w_push     = bus.req_valid && w_reqReady;
    assign w_newEntry = '{op:    decodeOp(bus.req_we, bus.req_clf),
                          addr:  bus.req_addr,
                          wdata: bus.req_wdata,
                          size:  bus.req_size};
    assign w_respDone = (r_state == S_WAIT_RESP) && bus.l2_resp_valid;
    assign w_readDone = w_respDone && (r_curOp == OP_RD);

    miss_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_newEntry),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; w_load copies the queue head onto the L2 outputs, w_pop retires it on handshake.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_nextState = S_ISSUE;
                    w_load      = 1'b1;
                end
            end
            S_ISSUE: begin
                if (bus.l2_req_ready) begin
                    w_pop       = 1'b1;
                    w_nextState = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (bus.l2_resp_valid) begin
                    if (r_curOp == OP_RD) begin
                        w_nextState = S_RETURN;
                    end else if (!w_empty) begin
                        w_nextState = S_ISSUE;
                        w_load      = 1'b1;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end
            end
            S_RETURN: begin
                if (!w_empty) begin
                    w_nextState = S_ISSUE;
                    w_load      = 1'b1;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // L2 request payload; captured once per op and held until the next op is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_curOp   <= OP_RD;
            r_l2We    <= 1'b0;
            r_l2Clf   <= 1'b0;
            r_l2Addr  <= '0;
            r_l2Wdata <= '0;
            r_l2Size  <= '0;
        end else if (w_load) begin
            r_curOp   <= w_head.op;
            r_l2We    <= (w_head.op == OP_WR);
            r_l2Clf   <= (w_head.op == OP_CLF);
            r_l2Addr  <= (w_head.op == OP_WR) ? w_head.addr : lineAlign(w_head.addr);
            r_l2Wdata <= w_head.wdata;
            r_l2Size  <= w_head.size;
        end
    end

    // Fill return path: pulse for one cycle after a read completes, keep the last line visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fillValid <= 1'b0;
            r_fillAddr  <= '0;
            r_fillData  <= '0;
        end else begin
            r_fillValid <= w_readDone;
            if (w_readDone) begin
                r_fillAddr <= r_l2Addr;
                r_fillData <= bus.l2_resp_data;
            end
        end
    end

    // Sticky error flag for an L2 response that arrives when nothing is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (bus.l2_resp_valid && (r_state != S_WAIT_RESP)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.req_ready      = w_reqReady;
    assign bus.l2_req_valid   = (r_state == S_ISSUE);
    assign bus.l2_we          = r_l2We;
    assign bus.l2_clf         = r_l2Clf;
    assign bus.l2_addr        = r_l2Addr;
    assign bus.l2_wdata       = r_l2Wdata;
    assign bus.l2_size        = r_l2Size;
    assign bus.fill_valid     = r_fillValid;
    assign bus.fill_addr      = r_fillAddr;
    assign bus.fill_data      = r_fillData;
    assign bus.err_unexp_resp = r_err;

`ifdef MISSBUF_STATS_EN
    logic [31:0] r_statReads;
    logic [31:0] r_statWrites;
    logic [31:0] r_statStall;

    // Saturating counters: completed reads, completed writes/flushes, and stalled request cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_statReads  <= '0;
            r_statWrites <= '0;
            r_statStall  <= '0;
        end else begin
            if (w_readDone && (r_statReads != '1)) begin
                r_statReads <= r_statReads + 32'd1;
            end
            if (w_respDone && (r_curOp != OP_RD) && (r_statWrites != '1)) begin
                r_statWrites <= r_statWrites + 32'd1;
            end
            if (bus.req_valid && !w_reqReady && (r_statStall != '1)) begin
                r_statStall <= r_statStall + 32'd1;
            end
        end
    end

    assign o_stat_reads  = r_statReads;
    assign o_stat_writes = r_statWrites;
    assign o_stat_stall  = r_statStall;
`endif

endmodule

// File: tb/tb_l1d_miss_buffer.sv
// Testbench for l1d_miss_buffer. A behavioural model (a queue of pending
// requests, one in-flight slot and an expected-fill slot) predicts every
// output each cycle; directed scenarios are followed by a randomized phase.
// Build with MISSBUF_STATS_EN defined to also check the statistics counters.
module tb_l1d_miss_buffer;
    import l1d_miss_buffer_pkg::*;

    typedef struct {
        logic        isRead;
        logic        isClf;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  size;
    } tbReq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    l1d_miss_buffer_if bus ();

`ifdef MISSBUF_STATS_EN
    logic [31:0] statReads;
    logic [31:0] statWrites;
    logic [31:0] statStall;
`endif

    l1d_miss_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MISSBUF_STATS_EN
        ,
        .o_stat_reads  (statReads),
        .o_stat_writes (statWrites),
        .o_stat_stall  (statStall)
`endif
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    tbReq_t       refQ[$];
    logic         inflight;
    logic         inflightRead;
    logic [63:0]  inflightAddr;
    logic         expectFill;
    logic [63:0]  expFillAddr;
    logic [127:0] expFillData;
    logic         errExp;
    int           modelReads;
    int           modelWrites;
    int           modelStall;
    int           vectors;
    int           miscompares;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        refQ.delete();
        inflight     = 1'b0;
        inflightRead = 1'b0;
        inflightAddr = '0;
        expectFill   = 1'b0;
        expFillAddr  = '0;
        expFillData  = '0;
        errExp       = 1'b0;
        modelReads   = 0;
        modelWrites  = 0;
        modelStall   = 0;
    endtask

    task automatic driveIdle();
        bus.req_valid     = 1'b0;
        bus.req_we        = 1'b0;
        bus.req_clf       = 1'b0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.req_size      = '0;
        bus.l2_req_ready  = 1'b0;
        bus.l2_resp_valid = 1'b0;
        bus.l2_resp_data  = '0;
    endtask

    // Compare every observable output against the model's prediction for this cycle.
    task automatic checkModel();
        tbReq_t h;
        checkOutput("reqReady", bus.req_ready, refQ.size() < MB_DEPTH);
        checkOutput("fillValid", bus.fill_valid, expectFill);
        if (expectFill) begin
            checkOutput("fillAddr", bus.fill_addr, expFillAddr);
            checkOutput("fillData", bus.fill_data, expFillData);
        end
        checkOutput("errFlag", bus.err_unexp_resp, errExp);
        if (bus.l2_req_valid) begin
            checkOutput("issueLegal", (refQ.size() > 0) && !inflight, 1'b1);
            if (refQ.size() > 0) begin
                h = refQ[0];
                checkOutput("l2Clf", bus.l2_clf, h.isClf);
                checkOutput("l2We", bus.l2_we, !h.isRead && !h.isClf);
                checkOutput("l2Addr", bus.l2_addr,
                            (h.isRead || h.isClf) ? (h.addr & ~64'h3F) : h.addr);
                if (!h.isRead && !h.isClf) begin
                    checkOutput("l2Wdata", bus.l2_wdata, h.wdata);
                    checkOutput("l2Size", bus.l2_size, h.size);
                end
            end
        end
    endtask

    // One cycle: check at the falling edge, drive inputs, advance the model across the rising edge.
    task automatic applyStimulus(input logic rv, input logic we, input logic clf,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [2:0] size, input logic l2rdy,
                                 input logic resp, input logic [127:0] rdata);
        logic   expReady;
        logic   sawValid;
        tbReq_t h;
        checkModel();
        expReady = (refQ.size() < MB_DEPTH);
        sawValid = bus.l2_req_valid;
        bus.req_valid     = rv;
        bus.req_we        = we;
        bus.req_clf       = clf;
        bus.req_addr      = addr;
        bus.req_wdata     = wdata;
        bus.req_size      = size;
        bus.l2_req_ready  = l2rdy;
        bus.l2_resp_valid = resp;
        bus.l2_resp_data  = rdata;
        @(posedge clk);
        expectFill = 1'b0;
        if (resp) begin
            if (inflight) begin
                if (inflightRead) begin
                    expectFill  = 1'b1;
                    expFillAddr = inflightAddr;
                    expFillData = rdata;
                    modelReads++;
                end else begin
                    modelWrites++;
                end
                inflight = 1'b0;
            end else begin
                errExp = 1'b1;
            end
        end
        if (sawValid && l2rdy && (refQ.size() > 0)) begin
            h            = refQ.pop_front();
            inflight     = 1'b1;
            inflightRead = h.isRead;
            inflightAddr = h.addr & ~64'h3F;
        end
        if (rv && expReady) begin
            h.isRead = !clf && !we;
            h.isClf  = clf;
            h.addr   = addr;
            h.wdata  = wdata;
            h.size   = size;
            refQ.push_back(h);
        end
        if (rv && !expReady) begin
            modelStall++;
        end
        @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "ReqReady"}, bus.req_ready, 1'b1);
        checkOutput({tag, "L2Valid"}, bus.l2_req_valid, 1'b0);
        checkOutput({tag, "L2Ctl"}, {bus.l2_we, bus.l2_clf, bus.l2_size}, 5'd0);
        checkOutput({tag, "L2Addr"}, bus.l2_addr, 64'd0);
        checkOutput({tag, "L2Wdata"}, bus.l2_wdata, 64'd0);
        checkOutput({tag, "FillValid"}, bus.fill_valid, 1'b0);
        checkOutput({tag, "FillAddr"}, bus.fill_addr, 64'd0);
        checkOutput({tag, "FillData"}, bus.fill_data, 128'd0);
        checkOutput({tag, "Err"}, bus.err_unexp_resp, 1'b0);
`ifdef MISSBUF_STATS_EN
        checkOutput({tag, "Stats"}, {statReads, statWrites, statStall}, 96'd0);
`endif
    endtask

    task automatic doReset();
        driveIdle();
        rst = 1'b1;
        #1;
        checkReset("rstHeld");
        @(negedge clk);
        rst = 1'b0;
        clearModel();
    endtask

    // Let the L2 accept and answer everything until the buffer is empty, bounded by a cycle budget.
    task automatic drain(input int budget);
        int n = 0;
        while ((n < budget) &&
               ((refQ.size() != 0) || inflight || expectFill || bus.l2_req_valid)) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0, 1'b1, inflight,
                          {$urandom(), $urandom(), $urandom(), $urandom()});
            n++;
        end
        checkOutput("drainDone", (refQ.size() == 0) && !inflight, 1'b1);
    endtask

    // Directed scenarios followed by a randomized phase, all in one linear sequence.
    initial begin
        int          fillSeen;
        logic [127:0] a5Line;
        vectors     = 0;
        miscompares = 0;
        clearModel();
        driveIdle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkReset("por");
        rst = 1'b0;

        // Single read miss: aligned L2 address, fill with the returned line.
        a5Line   = {16{8'hA5}};
        fillSeen = -1;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h1040, 64'd0, 3'd3, 1'b1, 1'b0, '0);
        for (int i = 1; i < 10; i++) begin
            if (bus.fill_valid && (fillSeen < 0)) begin
                fillSeen = i;
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0, 1'b1, inflight, a5Line);
        end
        checkOutput("readLatency", fillSeen >= 4, 1'b1);

        // Four writes with the L2 stalled fill the queue; the fifth request stalls.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 64'(32'h1000 * (i + 1)), 64'd8, 3'd3,
                          1'b0, 1'b0, '0);
        end
        checkOutput("fullReady", bus.req_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 64'h5000, 64'd8, 3'd3, 1'b0, 1'b0, '0);
        end
        checkOutput("holdValid", bus.l2_req_valid, 1'b1);
        checkOutput("holdAddr", bus.l2_addr, 64'h1000);
`ifdef MISSBUF_STATS_EN
        checkOutput("statStallScn2", statStall, 32'd5);
`endif
        drain(200);
`ifdef MISSBUF_STATS_EN
        checkOutput("statWritesScn2", statWrites, 32'd4);
        checkOutput("statReadsScn2", statReads, 32'd1);
`endif

        // Flush followed by a read: flush goes out aligned with l2_clf and returns no fill.
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h5010, 64'd0, 3'd0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h6048, 64'd0, 3'd0, 1'b0, 1'b0, '0);
        checkOutput("flushClf", bus.l2_clf, 1'b1);
        checkOutput("flushAddr", bus.l2_addr, 64'h5000);
        drain(200);

        // Stray response while idle sets the sticky error flag.
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b1, '0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, '0);
        checkOutput("errSticky", bus.err_unexp_resp, 1'b1);

        // Reset while a read is outstanding, then a late response flags an error.
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h7008, 64'd0, 3'd0, 1'b1, 1'b0, '0);
        for (int i = 0; (i < 10) && !inflight; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0, 1'b1, 1'b0, '0);
        end
        checkOutput("reachedWait", inflight, 1'b1);
        doReset();
        checkReset("midRst");
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b1, {4{32'hDEAD_BEEF}});
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, '0);
        checkOutput("lateRespErr", bus.err_unexp_resp, 1'b1);
        checkOutput("lateRespNoFill", bus.fill_valid, 1'b0);

        // Randomized traffic with random L2 back-pressure and response delay.
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 2);
            applyStimulus(1'($urandom_range(0, 1)), op == 1, op == 2,
                          {$urandom(), $urandom()}, {$urandom(), $urandom()},
                          3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                          inflight && ($urandom_range(0, 2) == 0),
                          {$urandom(), $urandom(), $urandom(), $urandom()});
        end
        drain(500);
`ifdef MISSBUF_STATS_EN
        checkOutput("statReads", statReads, 32'(modelReads));
        checkOutput("statWrites", statWrites, 32'(modelWrites));
        checkOutput("statStall", statStall, 32'(modelStall));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
